// File: rtl/uart_io_pkg.sv
// Purpose: shared register map, status bit positions and FSM state encoding for uart_io.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_io_pkg;

    // Register select values on the single address line
    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_STAT = 1'b1;

    // Bit positions inside the status register
    localparam int STAT_TXBUSY = 7;
    localparam int STAT_RXRDY  = 6;

    // Common state set for the TX and RX framers
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Purpose: reloadable down-counter that marks the end of each bit period.
// Latency: tick is asserted exactly L+1 edges after a load of value L, then every N edges.
// Backpressure: none; free-running between loads.
//
// Ports:
//   clk, rst   clock and synchronous active-low reset
//   load       force a reload this edge (overrides the free-running reload)
//   half       with load: preload a half bit period instead of a full one
//   tick       combinational; high on the last clock of the current period
module uart_baud_cnt #(
    parameter int N = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic half,
    output logic tick
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] FULL = W'(N - 1);
    localparam logic [W-1:0] HALF = W'(N / 2 - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= half ? HALF : FULL;
        end else if (cnt == '0) begin
            cnt <= FULL;
        end else begin
            cnt <= cnt - W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_io.sv
// Purpose: 8N1 UART peripheral with a data register (write = transmit, read = last RX byte) and a status register.
// Latency: accepted write on edge k drives the start bit after edge k+1; frame lasts 10*N clocks; register reads are combinational.
// Backpressure: writes while the transmitter is busy are dropped; a new RX byte overwrites an unread one.
//
// Ports:
//   clk, rst   clock and synchronous active-low reset
//   cs, we     chip select and write enable (we qualified by cs)
//   addr       0 = data register, 1 = status {tx_busy, rx_ready, 6'b0}
//   dbw, dbr   write data in, read data out (dbr ignores cs)
//   tx, rx     serial line out / in, both idle high; rx is asynchronous
module uart_io
    import uart_io_pkg::*;
#(
    parameter int CLK_HZ = 1843200,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       we,
    input  logic       addr,
    input  logic [7:0] dbw,
    output logic [7:0] dbr,
    output logic       tx,
    input  logic       rx
);

    localparam int N = CLK_HZ / BAUD;

    logic wr_data;
    logic rd_data;

    assign wr_data = cs & we & (addr == ADDR_DATA);
    assign rd_data = cs & ~we & (addr == ADDR_DATA);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_t tx_state;
    logic [7:0]  tx_sh;
    logic [2:0]  tx_bit;
    logic        tx_pend;
    logic        tx_busy;
    logic        tx_tick;
    logic        tx_load;

    // The accepted byte waits one clock in tx_pend so the start bit and
    // tx_busy both appear after the edge following the write.
    assign tx_load = (tx_state == ST_IDLE) & tx_pend;

    uart_baud_cnt #(.N(N)) u_tx_baud (
        .clk  (clk),
        .rst  (rst),
        .load (tx_load),
        .half (1'b0),
        .tick (tx_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= ST_IDLE;
            tx_sh    <= '0;
            tx_bit   <= '0;
            tx_pend  <= 1'b0;
            tx_busy  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (tx_pend) begin
                        tx_state <= ST_START;
                        tx_pend  <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx       <= 1'b0;
                    end else if (wr_data) begin
                        tx_pend <= 1'b1;
                        tx_sh   <= dbw;
                    end
                end
                ST_START: begin
                    if (tx_tick) begin
                        tx_state <= ST_DATA;
                        tx_bit   <= '0;
                        tx       <= tx_sh[0];
                        tx_sh    <= {1'b0, tx_sh[7:1]};
                    end
                end
                ST_DATA: begin
                    if (tx_tick) begin
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                            tx       <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx     <= tx_sh[0];
                            tx_sh  <= {1'b0, tx_sh[7:1]};
                        end
                    end
                end
                ST_STOP: begin
                    if (tx_tick) begin
                        tx_state <= ST_IDLE;
                        tx_busy  <= 1'b0;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    uart_state_t rx_state;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_d;
    logic [7:0]  rx_sh;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_tick;
    logic        rx_fall;
    logic        rx_load;

    assign rx_fall = rx_d & ~rx_s2;
    assign rx_load = (rx_state == ST_IDLE) & rx_fall;

    // Half-period preload puts every later tick near the middle of a bit.
    uart_baud_cnt #(.N(N)) u_rx_baud (
        .clk  (clk),
        .rst  (rst),
        .load (rx_load),
        .half (1'b1),
        .tick (rx_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            rx_state <= ST_IDLE;
            rx_sh    <= '0;
            rx_bit   <= '0;
            rx_data  <= '0;
            rx_ready <= 1'b0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;

            // Clear first; a completing byte below overrides it on the same edge.
            if (rd_data) begin
                rx_ready <= 1'b0;
            end

            case (rx_state)
                ST_IDLE: begin
                    if (rx_fall) begin
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_tick) begin
                        // Line back high at mid start bit: treat as a glitch.
                        if (rx_s2) begin
                            rx_state <= ST_IDLE;
                        end else begin
                            rx_state <= ST_DATA;
                            rx_bit   <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_tick) begin
                        rx_sh <= {rx_s2, rx_sh[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (rx_tick) begin
                        rx_state <= ST_IDLE;
                        // Low stop bit is a framing error: byte dropped, flag untouched.
                        if (rx_s2) begin
                            rx_data  <= rx_sh;
                            rx_ready <= 1'b1;
                        end
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        dbr = '0;
        if (addr == ADDR_STAT) begin
            dbr[STAT_TXBUSY] = tx_busy;
            dbr[STAT_RXRDY]  = rx_ready;
        end else begin
            dbr = rx_data;
        end
    end

endmodule

// File: tb/tb_uart_io.sv
module tb_uart_io;

    localparam int N      = 9;
    localparam int BAUD   = 115200;
    localparam int CLK_HZ = 9 * 115200;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic       cs   = 1'b0;
    logic       we   = 1'b0;
    logic       addr = 1'b0;
    logic [7:0] dbw  = 8'h00;
    logic [7:0] dbr;
    logic       tx;
    logic       rx   = 1'b1;

    uart_io #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .we   (we),
        .addr (addr),
        .dbw  (dbw),
        .dbr  (dbr),
        .tx   (tx),
        .rx   (rx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One transmit frame is described by its accept edge fk and byte fb;
    // the line level at any cycle follows from the 8N1 bit layout.
    bit         fvalid    = 1'b0;
    int         fk        = 0;
    logic [7:0] fb        = 8'h00;
    bit         rxr_m     = 1'b0;
    logic [7:0] rxd_m     = 8'h00;
    int         rx_frames = 0;
    int         rx_seen   = 0;
    logic [7:0] rx_byte   = 8'h00;
    bit         rx_unc    = 1'b0;
    bit         armed     = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            fvalid = 1'b0;
            rxr_m  = 1'b0;
            rxd_m  = 8'h00;
        end else begin
            if (cs && we && addr == 1'b0 && !(fvalid && cyc <= fk + 1 + 10 * N)) begin
                fvalid = 1'b1;
                fk     = cyc;
                fb     = dbw;
            end
            if (cs && !we && addr == 1'b0) rxr_m = 1'b0;
            if (rx_frames != rx_seen) begin
                rxr_m = 1'b1;
                rxd_m = rx_byte;
            end
        end
        rx_seen = rx_frames;
    end

    function automatic logic exp_tx();
        int j;
        if (!fvalid) return 1'b1;
        j = cyc - (fk + 1);
        if (j < 0 || j >= 10 * N) return 1'b1;
        if (j / N == 0) return 1'b0;
        if (j / N == 9) return 1'b1;
        return fb[j / N - 1];
    endfunction

    function automatic logic exp_busy();
        return fvalid && cyc >= fk + 1 && cyc <= fk + 10 * N;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            chk("tx_line", 8'(tx), 8'(exp_tx()));
            if (addr) begin
                chk("stat_txbusy", 8'(dbr[7]), 8'(exp_busy()));
                if (!rx_unc) chk("stat_rxrdy", 8'(dbr[6]), 8'(rxr_m));
                chk("stat_low_bits", 8'(dbr[5:0]), 8'h00);
            end else if (!rx_unc) begin
                chk("data_reg", dbr, rxd_m);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = 1'b0; dbw = d;
        tick(1);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic a, output logic [7:0] v);
        cs = 1'b1; we = 1'b0; addr = a;
        #1 v = dbr;
        tick(1);
        cs = 1'b0;
    endtask

    task automatic peek(input logic a, output logic [7:0] v);
        addr = a;
        #1 v = dbr;
    endtask

    // Called ofs cycles after the accept edge; samples each bit mid-period.
    task automatic check_frame(input string nm, input int ofs, input logic [9:0] pat);
        tick(5 - ofs);
        for (int i = 0; i < 10; i++) begin
            chk(nm, 8'(tx), 8'(pat[i]));
            tick(N);
        end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic good);
        logic [9:0] f;
        f = {good, b, 1'b0};
        rx_unc = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            tick(N);
        end
        rx = 1'b1;
        tick(3);
        if (good) begin
            rx_byte = b;
            rx_frames++;
        end
        tick(1);
        rx_unc = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    logic [7:0] v;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        armed = 1'b1;
        chk("reset_tx", 8'(tx), 8'h01);
        peek(1'b0, v); chk("reset_data", v, 8'h00);
        peek(1'b1, v); chk("reset_stat", v, 8'h00);
        rst = 1'b1;
        tick(2);
        peek(1'b0, v); chk("post_reset_data", v, 8'h00);
        tick(1);

        // 0x7B frame, plus a dropped write of 0x3E three clocks later
        wr(8'h7B);
        peek(1'b0, v); chk("data_during_wr", v, 8'h00);
        tick(2);
        wr(8'h3E);
        check_frame("frame_7b", 3, 10'b1011110110);
        tick(20);
        chk("idle_after_7b", 8'(tx), 8'h01);

        // Busy window for 0xFF
        wr(8'hFF);
        tick(11);
        rd(1'b1, v); chk("busy_at_11", 8'(v[7]), 8'h01);
        tick(10);
        rd(1'b1, v); chk("busy_at_22", 8'(v[7]), 8'h01);
        tick(77);
        rd(1'b1, v); chk("busy_at_100", 8'(v[7]), 8'h00);
        tick(5);

        // Receive 0xA5, then clear by reading data
        send_rx(8'hA5, 1'b1);
        peek(1'b1, v); chk("rx_ready_set", 8'(v[6]), 8'h01);
        rd(1'b0, v);   chk("rx_data_a5", v, 8'hA5);
        peek(1'b1, v); chk("rx_ready_cleared", 8'(v[6]), 8'h00);
        tick(3);

        // Short glitch on rx must not start a byte
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(20);
        peek(1'b1, v); chk("glitch_no_ready", 8'(v[6]), 8'h00);
        peek(1'b0, v); chk("glitch_data_kept", v, 8'hA5);
        tick(3);

        // Framing error: byte dropped, flag unchanged
        send_rx(8'h3C, 1'b0);
        tick(5);
        peek(1'b1, v); chk("ferr_no_ready", 8'(v[6]), 8'h00);
        peek(1'b0, v); chk("ferr_data_kept", v, 8'hA5);
        tick(3);

        // Reset in the middle of a frame, then a clean 0x00 frame
        wr(8'h55);
        tick(30);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk("midframe_reset_tx", 8'(tx), 8'h01);
        peek(1'b1, v); chk("midframe_reset_stat", v, 8'h00);
        tick(2);
        wr(8'h00);
        check_frame("frame_00", 0, 10'b1000000000);
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
